// File: rtl/branch_issue_queue.sv
// Branch reservation station: advertises free slots a cycle ahead, wakes operands from the CDB,
// and presents the oldest fully-ready entry to a single branch unit.
module branch_issue_queue #(
  parameter int DEPTH      = 8,
  parameter int DISPATCH_W = 2,
  parameter int CDB_W      = 2,
  parameter int ROB_W      = 4,
  parameter int OP_W       = 6,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  output logic [DISPATCH_W-1:0]         alloc_ready,
  output logic [DISPATCH_W*IDX_W-1:0]   alloc_index,
  input  logic [DISPATCH_W-1:0]         disp_taken,
  input  logic [DISPATCH_W*OP_W-1:0]    disp_op,
  input  logic [DISPATCH_W*32-1:0]      disp_pc,
  input  logic [DISPATCH_W*ROB_W-1:0]   disp_rob,
  input  logic [DISPATCH_W*2*32-1:0]    disp_src_val,
  input  logic [DISPATCH_W*2*ROB_W-1:0] disp_src_tag,
  input  logic [DISPATCH_W*2-1:0]       disp_src_rdy,
  input  logic [CDB_W-1:0]              cdb_valid,
  input  logic [CDB_W*ROB_W-1:0]        cdb_tag,
  input  logic [CDB_W*32-1:0]           cdb_data,
  output logic                          iss_valid,
  input  logic                          iss_ready,
  output logic [OP_W-1:0]               iss_op,
  output logic [31:0]                   iss_pc,
  output logic [ROB_W-1:0]              iss_rob,
  output logic [2*32-1:0]               iss_src,
  output logic [IDX_W:0]                occupancy
);

  logic [DEPTH-1:0]            busy_q, busy_d;
  logic [OP_W-1:0]             op_q [DEPTH], op_d [DEPTH];
  logic [31:0]                 pc_q [DEPTH], pc_d [DEPTH];
  logic [ROB_W-1:0]            rob_q [DEPTH], rob_d [DEPTH];
  logic [1:0][31:0]            val_q [DEPTH], val_d [DEPTH];
  logic [1:0][ROB_W-1:0]       tag_q [DEPTH], tag_d [DEPTH];
  logic [1:0]                  rdy_q [DEPTH], rdy_d [DEPTH];
  // age_q[i][j] = 1 means entry i is older than entry j
  logic [DEPTH-1:0]            age_q [DEPTH], age_d [DEPTH];
  logic [DISPATCH_W-1:0]       alloc_ready_q, alloc_ready_d;
  logic [IDX_W-1:0]            alloc_index_q [DISPATCH_W], alloc_index_d [DISPATCH_W];
  logic [IDX_W:0]              occ_q, occ_d;

  logic [DEPTH-1:0]            cand_s, sel_oh_s;
  logic [IDX_W-1:0]            sel_idx_s, slot_s;
  logic [DISPATCH_W-1:0]       disp_we_s;
  logic                        blocked_s;
  logic [IDX_W:0]              free_cnt_s;

  // oldest-ready select, purely from registered state
  always_comb begin
    cand_s    = '0;
    sel_oh_s  = '0;
    sel_idx_s = '0;
    blocked_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) cand_s[i] = busy_q[i] & (&rdy_q[i]);
    for (int i = 0; i < DEPTH; i++) begin
      blocked_s = 1'b0;
      for (int j = 0; j < DEPTH; j++) blocked_s = blocked_s | (cand_s[j] & age_q[j][i]);
      sel_oh_s[i] = cand_s[i] & ~blocked_s;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh_s[i]) sel_idx_s = IDX_W'(i);
      else             sel_idx_s = sel_idx_s;
    end
    iss_valid = |cand_s;
    iss_op    = iss_valid ? op_q[sel_idx_s]  : '0;
    iss_pc    = iss_valid ? pc_q[sel_idx_s]  : '0;
    iss_rob   = iss_valid ? rob_q[sel_idx_s] : '0;
    iss_src   = iss_valid ? val_q[sel_idx_s] : '0;
  end

  // wakeup, pop and dispatch (with CDB bypass) next-state
  always_comb begin
    busy_d = busy_q; op_d = op_q; pc_d = pc_q; rob_d = rob_q;
    val_d = val_q; tag_d = tag_q; rdy_d = rdy_q; age_d = age_q;
    slot_s = '0;
    // scanning CDB ports high-to-low lets the lower port win on duplicate tags
    for (int i = 0; i < DEPTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        for (int c = CDB_W - 1; c >= 0; c--) begin
          if (busy_q[i] && !rdy_q[i][s] && cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == tag_q[i][s]) begin
            rdy_d[i][s] = 1'b1;
            val_d[i][s] = cdb_data[c*32 +: 32];
          end else begin
            rdy_d[i][s] = rdy_d[i][s];
          end
        end
      end
    end
    if (iss_valid && iss_ready) busy_d[sel_idx_s] = 1'b0;
    else                        busy_d = busy_d;
    disp_we_s = disp_taken & alloc_ready_q;
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (disp_we_s[k]) begin
        slot_s         = alloc_index_q[k];
        busy_d[slot_s] = 1'b1;
        op_d[slot_s]   = disp_op[k*OP_W +: OP_W];
        pc_d[slot_s]   = disp_pc[k*32 +: 32];
        rob_d[slot_s]  = disp_rob[k*ROB_W +: ROB_W];
        for (int s = 0; s < 2; s++) begin
          val_d[slot_s][s] = disp_src_val[(k*2+s)*32 +: 32];
          tag_d[slot_s][s] = disp_src_tag[(k*2+s)*ROB_W +: ROB_W];
          rdy_d[slot_s][s] = disp_src_rdy[k*2+s];
          for (int c = CDB_W - 1; c >= 0; c--) begin
            if (!disp_src_rdy[k*2+s] && cdb_valid[c] && cdb_tag[c*ROB_W +: ROB_W] == disp_src_tag[(k*2+s)*ROB_W +: ROB_W]) begin
              rdy_d[slot_s][s] = 1'b1;
              val_d[slot_s][s] = cdb_data[c*32 +: 32];
            end else begin
              rdy_d[slot_s][s] = rdy_d[slot_s][s];
            end
          end
        end
        // new entry is younger than every current entry and every lower dispatch port
        for (int j = 0; j < DEPTH; j++) begin
          age_d[slot_s][j] = 1'b0;
          age_d[j][slot_s] = busy_q[j];
        end
        for (int m = 0; m < k; m++) begin
          if (disp_we_s[m]) age_d[alloc_index_q[m]][slot_s] = 1'b1;
          else              age_d[slot_s] = age_d[slot_s];
        end
      end else begin
        slot_s = slot_s;
      end
    end
  end

  // next-cycle slot offers from the lowest free slots, plus occupancy
  always_comb begin
    alloc_ready_d = '0;
    free_cnt_s    = '0;
    occ_d         = '0;
    for (int k = 0; k < DISPATCH_W; k++) alloc_index_d[k] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy_d[i]) begin
        for (int k = 0; k < DISPATCH_W; k++) begin
          if (free_cnt_s == (IDX_W+1)'(k)) begin
            alloc_ready_d[k] = 1'b1;
            alloc_index_d[k] = IDX_W'(i);
          end else begin
            alloc_ready_d[k] = alloc_ready_d[k];
          end
        end
        free_cnt_s = free_cnt_s + 1'b1;
      end else begin
        occ_d = occ_d + 1'b1;
      end
    end
  end

  // control state: reset and flush clear busy, age and allocation
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_q        <= '0;
      alloc_ready_q <= '1;
      occ_q         <= '0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      for (int k = 0; k < DISPATCH_W; k++) alloc_index_q[k] <= IDX_W'(k);
    end else begin
      busy_q        <= busy_d;
      alloc_ready_q <= alloc_ready_d;
      occ_q         <= occ_d;
      age_q         <= age_d;
      alloc_index_q <= alloc_index_d;
    end
  end

  // entry payload; contents are don't-care while the slot is not busy
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    pc_q  <= pc_d;
    rob_q <= rob_d;
    val_q <= val_d;
    tag_q <= tag_d;
    rdy_q <= rdy_d;
  end

  // flatten per-port allocation offers
  always_comb begin
    alloc_ready = alloc_ready_q;
    occupancy   = occ_q;
    alloc_index = '0;
    for (int k = 0; k < DISPATCH_W; k++) alloc_index[k*IDX_W +: IDX_W] = alloc_index_q[k];
  end

endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed-vector bench for branch_issue_queue with hand-computed expectations.
module tb_branch_issue_queue;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  alloc_ready;
  logic [5:0]  alloc_index;
  logic [1:0]  disp_taken;
  logic [11:0] disp_op;
  logic [63:0] disp_pc;
  logic [7:0]  disp_rob;
  logic [127:0] disp_src_val;
  logic [15:0] disp_src_tag;
  logic [3:0]  disp_src_rdy;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        iss_valid, iss_ready;
  logic [5:0]  iss_op;
  logic [31:0] iss_pc;
  logic [3:0]  iss_rob;
  logic [63:0] iss_src;
  logic [3:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;

  branch_issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .disp_taken(disp_taken), .disp_op(disp_op), .disp_pc(disp_pc), .disp_rob(disp_rob),
    .disp_src_val(disp_src_val), .disp_src_tag(disp_src_tag), .disp_src_rdy(disp_src_rdy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_pc(iss_pc),
    .iss_rob(iss_rob), .iss_src(iss_src), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    disp_taken   = 2'b00;
    disp_op      = '0;
    disp_pc      = '0;
    disp_rob     = '0;
    disp_src_val = '0;
    disp_src_tag = '0;
    disp_src_rdy = 4'b0000;
    cdb_valid    = 2'b00;
    cdb_tag      = '0;
    cdb_data     = '0;
  endtask

  // src1 is always ready; src0 readiness/tag/value chosen per vector
  task automatic put(input int k, input logic [3:0] rob, input logic rdy0, input logic [3:0] tag0,
                     input logic [31:0] v0, input logic [31:0] v1);
    disp_taken[k]                   = 1'b1;
    disp_op[k*6 +: 6]               = {2'b00, rob} + 6'd1;
    disp_pc[k*32 +: 32]             = 32'h0000_1000 + {26'd0, rob, 2'b00};
    disp_rob[k*4 +: 4]              = rob;
    disp_src_val[(k*2)*32 +: 32]    = v0;
    disp_src_val[(k*2+1)*32 +: 32]  = v1;
    disp_src_tag[(k*2)*4 +: 4]      = tag0;
    disp_src_tag[(k*2+1)*4 +: 4]    = 4'd0;
    disp_src_rdy[k*2]               = rdy0;
    disp_src_rdy[k*2+1]             = 1'b1;
  endtask

  initial begin
    clr_in();
    rst = 1'b1; flush = 1'b0; iss_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_eq("rst_occ", 64'(occupancy), 64'd0);
    check_eq("rst_valid", 64'(iss_valid), 64'd0);
    check_eq("rst_aready", 64'(alloc_ready), 64'd3);
    check_eq("rst_aidx", 64'(alloc_index), 64'd8);

    // two ready branches in one cycle: port 0 is older
    put(0, 4'd3, 1'b1, 4'd0, 32'hA0, 32'hA1);
    put(1, 4'd5, 1'b1, 4'd0, 32'hB0, 32'hB1);
    tick(); clr_in();
    check_eq("dual_valid", 64'(iss_valid), 64'd1);
    check_eq("dual_rob0", 64'(iss_rob), 64'd3);
    check_eq("dual_pc0", 64'(iss_pc), 64'h100C);
    check_eq("dual_op0", 64'(iss_op), 64'd4);
    check_eq("dual_src0", iss_src, 64'h0000_00A1_0000_00A0);
    check_eq("dual_occ", 64'(occupancy), 64'd2);
    check_eq("dual_aidx", 64'(alloc_index), 64'd26);
    iss_ready = 1'b1;
    tick();
    check_eq("dual_rob1", 64'(iss_rob), 64'd5);
    check_eq("dual_occ1", 64'(occupancy), 64'd1);
    tick();
    check_eq("dual_empty", 64'(iss_valid), 64'd0);
    check_eq("dual_occ0", 64'(occupancy), 64'd0);
    iss_ready = 1'b0;

    // fill all eight entries waiting on tag 7
    for (int c = 0; c < 4; c++) begin
      put(0, 4'(2*c), 1'b0, 4'd7, 32'd0, 32'h10);
      put(1, 4'(2*c+1), 1'b0, 4'd7, 32'd0, 32'h10);
      tick();
    end
    clr_in();
    check_eq("full_aready", 64'(alloc_ready), 64'd0);
    check_eq("full_occ", 64'(occupancy), 64'd8);
    check_eq("full_wait", 64'(iss_valid), 64'd0);
    // CDB port 1 wakes all; dispatch while full is a protocol error and is dropped
    cdb_valid = 2'b10; cdb_tag[4 +: 4] = 4'd7; cdb_data[32 +: 32] = 32'h0000_DEAD;
    put(0, 4'd15, 1'b1, 4'd0, 32'h1, 32'h2);
    put(1, 4'd14, 1'b1, 4'd0, 32'h1, 32'h2);
    tick(); clr_in();
    check_eq("wake_valid", 64'(iss_valid), 64'd1);
    check_eq("wake_occ", 64'(occupancy), 64'd8);
    iss_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_rob", 64'(iss_rob), 64'(i));
      check_eq("drain_src", 64'(iss_src[31:0]), 64'h0000_DEAD);
      tick();
    end
    check_eq("drain_occ", 64'(occupancy), 64'd0);
    check_eq("drain_valid", 64'(iss_valid), 64'd0);
    iss_ready = 1'b0;

    // dispatch bypass, duplicate CDB tag: lower port wins
    put(0, 4'd9, 1'b0, 4'd2, 32'd0, 32'h77);
    cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd2}; cdb_data = {32'h99, 32'h55};
    tick(); clr_in();
    check_eq("byp_valid", 64'(iss_valid), 64'd1);
    check_eq("byp_rob", 64'(iss_rob), 64'd9);
    check_eq("byp_src", iss_src, 64'h0000_0077_0000_0055);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    check_eq("byp_occ", 64'(occupancy), 64'd0);

    // backpressure holds the oldest entry
    put(0, 4'd10, 1'b1, 4'd0, 32'h1, 32'h2);
    put(1, 4'd11, 1'b1, 4'd0, 32'h1, 32'h2);
    tick(); clr_in();
    put(0, 4'd12, 1'b1, 4'd0, 32'h1, 32'h2);
    tick(); clr_in();
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_rob", 64'(iss_rob), 64'd10);
      check_eq("hold_occ", 64'(occupancy), 64'd3);
      tick();
    end
    check_eq("hold_rob_end", 64'(iss_rob), 64'd10);
    // release while dispatching; rob 15 lands in low slot 0 but stays youngest
    iss_ready = 1'b1;
    put(0, 4'd14, 1'b1, 4'd0, 32'h1, 32'h2);
    tick(); clr_in();
    check_eq("rel_rob11", 64'(iss_rob), 64'd11);
    check_eq("rel_occ3", 64'(occupancy), 64'd3);
    check_eq("rel_aidx", 64'(alloc_index), 64'd32);
    put(0, 4'd15, 1'b1, 4'd0, 32'h1, 32'h2);
    tick(); clr_in();
    check_eq("rel_rob12", 64'(iss_rob), 64'd12);
    check_eq("rel_occ3b", 64'(occupancy), 64'd3);
    tick();
    check_eq("rel_rob14", 64'(iss_rob), 64'd14);
    check_eq("rel_occ2", 64'(occupancy), 64'd2);
    tick();
    check_eq("rel_rob15", 64'(iss_rob), 64'd15);
    check_eq("rel_occ1", 64'(occupancy), 64'd1);
    tick();
    check_eq("rel_empty", 64'(iss_valid), 64'd0);
    check_eq("rel_occ0", 64'(occupancy), 64'd0);
    iss_ready = 1'b0;

    // flush dominates concurrent dispatch and issue
    for (int c = 0; c < 3; c++) begin
      put(0, 4'(2*c), 1'b1, 4'd0, 32'h1, 32'h2);
      put(1, 4'(2*c+1), 1'b1, 4'd0, 32'h1, 32'h2);
      tick();
    end
    clr_in();
    check_eq("pre_flush_occ", 64'(occupancy), 64'd6);
    flush = 1'b1; iss_ready = 1'b1;
    put(0, 4'd8, 1'b1, 4'd0, 32'h1, 32'h2);
    put(1, 4'd9, 1'b1, 4'd0, 32'h1, 32'h2);
    tick();
    flush = 1'b0; iss_ready = 1'b0; clr_in();
    check_eq("flush_occ", 64'(occupancy), 64'd0);
    check_eq("flush_valid", 64'(iss_valid), 64'd0);
    check_eq("flush_rob", 64'(iss_rob), 64'd0);
    check_eq("flush_aready", 64'(alloc_ready), 64'd3);
    check_eq("flush_aidx", 64'(alloc_index), 64'd8);
    put(0, 4'd9, 1'b1, 4'd0, 32'h1, 32'h2);
    tick(); clr_in();
    check_eq("post_flush_rob", 64'(iss_rob), 64'd9);
    check_eq("post_flush_occ", 64'(occupancy), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
